reset_source_conditioner: RTL and testbench

//  Conditions raw board/system reset sources into the clean active-low vector that feeds the

---
 rtl/reset_ctrl_pkg.sv | 22 ++
 rtl/reset_debounce_filter.sv | 53 +++++
 rtl/reset_source_conditioner.sv | 149 ++++++++++++++
 tb/tb_reset_source_conditioner.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared types and constants for the reset source conditioning slice.
package reset_ctrl_pkg;

  // PLL lock qualification states
  typedef enum logic [1:0] {
    LK_DOWN = 2'd0,
    LK_QUAL = 2'd1,
    LK_UP   = 2'd2
  } lock_state_t;

  // Bit positions inside the conditioned external reset vector
  localparam int NUM_EXTERNAL_RESETS = 3;
  localparam int EXT_IDX_PLL         = 2;
  localparam int EXT_IDX_PIN         = 1;
  localparam int EXT_IDX_FATAL       = 0;

  // Width of a counter that must hold the values 0 .. n-1 (never narrower than 1 bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_debounce_filter.sv
// Two-flop synchroniser followed by a symmetric debounce filter. The filtered
// output only changes after the synchronised input has disagreed with it for
// CYCLES consecutive clocks; any agreeing sample restarts the count.
module reset_debounce_filter
  import reset_ctrl_pkg::*;
#(
  parameter int CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_raw,
  output logic o_filt
);

  localparam int              CW   = cnt_w(CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_out;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous input into the clock domain
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive disagreeing samples; flip the output on the last one
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_out <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 != r_out) begin
      if (r_cnt == LAST) begin
        r_out <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_filt = r_out;

endmodule

// File: rtl/reset_source_conditioner.sv
// Turns the raw board reset sources (reset pin, PLL lock, fatal error) into the
// registered active-low vector {pll_ok, pin_ok, !fatal} that feeds the reset
// domain synchroniser. Every bit is held low for a minimum number of cycles.
module reset_source_conditioner
  import reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int MIN_PULSE_CYCLES   = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           rstn_pin_raw,
  input  logic                           pll_lock_raw,
  input  logic                           fatal_error,
  input  logic                           error_clear,
  output logic [NUM_EXTERNAL_RESETS-1:0] ext_rstn,
  output logic                           fatal_latched,
  output logic [7:0]                     lock_loss_count
);

  localparam int            LW      = cnt_w(LOCK_STABLE_CYCLES);
  localparam logic [LW-1:0] LK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
  localparam int            PW      = cnt_w(MIN_PULSE_CYCLES);
  localparam logic [PW-1:0] MP_LAST = PW'(MIN_PULSE_CYCLES - 1);

  logic                           r_lock_s1;
  logic                           r_lock_s2;
  lock_state_t                    r_lk_state;
  logic [LW-1:0]                  r_lk_cnt;
  logic [7:0]                     r_loss_cnt;
  logic                           r_fatal;
  logic [NUM_EXTERNAL_RESETS-1:0] r_ext;
  logic [PW-1:0]                  r_mp [NUM_EXTERNAL_RESETS];

  logic                           w_pin_filt;
  logic                           w_lk_up_nxt;
  logic                           w_fatal_nxt;
  logic [NUM_EXTERNAL_RESETS-1:0] w_req;

  reset_debounce_filter #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_pin_filter (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_raw  (rstn_pin_raw),
    .o_filt (w_pin_filt)
  );

  // Synchronise the PLL lock indicator
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= pll_lock_raw;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // Release requests per bit. The PLL and fatal bits use the next-state decode so
  // a lock loss or fatal request reaches the output register on the same edge.
  always_comb begin
    w_lk_up_nxt = r_lock_s2 &&
                  ((r_lk_state == LK_UP) ||
                   ((r_lk_state == LK_QUAL) && (r_lk_cnt == LK_LAST)));
    w_fatal_nxt = fatal_error | (r_fatal & ~error_clear);
    w_req                = '0;
    w_req[EXT_IDX_PLL]   = w_lk_up_nxt;
    w_req[EXT_IDX_PIN]   = w_pin_filt;
    w_req[EXT_IDX_FATAL] = ~w_fatal_nxt;
  end

  // Lock qualification FSM and saturating lock-loss counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lk_state <= LK_DOWN;
      r_lk_cnt   <= '0;
      r_loss_cnt <= '0;
    end else begin
      case (r_lk_state)
        LK_DOWN: begin
          if (r_lock_s2) begin
            r_lk_state <= LK_QUAL;
            r_lk_cnt   <= '0;
          end
        end
        LK_QUAL: begin
          if (!r_lock_s2) begin
            r_lk_state <= LK_DOWN;
          end else if (r_lk_cnt == LK_LAST) begin
            r_lk_state <= LK_UP;
          end else begin
            r_lk_cnt <= r_lk_cnt + 1'b1;
          end
        end
        LK_UP: begin
          if (!r_lock_s2) begin
            r_lk_state <= LK_DOWN;
            if (r_loss_cnt != 8'hFF) begin
              r_loss_cnt <= r_loss_cnt + 8'd1;
            end
          end
        end
        default: r_lk_state <= LK_DOWN;
      endcase
    end
  end

  // Sticky fatal flag; a set request wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fatal <= 1'b0;
    end else begin
      r_fatal <= w_fatal_nxt;
    end
  end

  // Minimum low-pulse stretcher. r_mp counts cycles spent low since the fall
  // (or since reset), saturating at MIN_PULSE_CYCLES-1; release waits for it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ext <= '0;
      for (int i = 0; i < NUM_EXTERNAL_RESETS; i++) begin
        r_mp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_EXTERNAL_RESETS; i++) begin
        if (r_ext[i]) begin
          if (!w_req[i]) begin
            r_ext[i] <= 1'b0;
            r_mp[i]  <= '0;
          end
        end else if (r_mp[i] == MP_LAST) begin
          if (w_req[i]) begin
            r_ext[i] <= 1'b1;
          end
        end else begin
          r_mp[i] <= r_mp[i] + 1'b1;
        end
      end
    end
  end

  assign ext_rstn        = r_ext;
  assign fatal_latched   = r_fatal;
  assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_reset_source_conditioner.sv
// Directed bench for reset_source_conditioner with short debounce, lock and
// pulse parameters; expected values are worked out by hand from the edge timing.
module tb_reset_source_conditioner;

  logic       clk;
  logic       rstn;
  logic       rstn_pin_raw;
  logic       pll_lock_raw;
  logic       fatal_error;
  logic       error_clear;
  logic [2:0] ext_rstn;
  logic       fatal_latched;
  logic [7:0] lock_loss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_loss = 0;

  reset_source_conditioner #(
    .DEBOUNCE_CYCLES    (8),
    .LOCK_STABLE_CYCLES (16),
    .MIN_PULSE_CYCLES   (4)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .rstn_pin_raw    (rstn_pin_raw),
    .pll_lock_raw    (pll_lock_raw),
    .fatal_error     (fatal_error),
    .error_clear     (error_clear),
    .ext_rstn        (ext_rstn),
    .fatal_latched   (fatal_latched),
    .lock_loss_count (lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; rstn_pin_raw = 1'b1; pll_lock_raw = 1'b1;
    fatal_error = 1'b0; error_clear = 1'b0;

    // 1: reset and staged release
    tick(5);
    chk("rst_ext", 32'(ext_rstn), 32'h0);
    chk("rst_fatal", 32'(fatal_latched), 32'h0);
    chk("rst_cnt", 32'(lock_loss_count), 32'h0);
    rstn = 1'b1;
    tick(3);  chk("rel_e3", 32'(ext_rstn), 32'b000);
    tick(1);  chk("rel_e4", 32'(ext_rstn), 32'b001);
    tick(6);  chk("rel_e10", 32'(ext_rstn), 32'b001);
    tick(1);  chk("rel_e11", 32'(ext_rstn), 32'b011);
    tick(7);  chk("rel_e18", 32'(ext_rstn), 32'b011);
    tick(1);  chk("rel_e19", 32'(ext_rstn), 32'b111);
    chk("rel_cnt", 32'(lock_loss_count), 32'h0);

    // 2: lock loss, recovery, glitch during qualification
    pll_lock_raw = 1'b0;
    tick(2);  chk("loss_l2", 32'(ext_rstn), 32'b111);
    tick(1);  chk("loss_l3", 32'(ext_rstn), 32'b011);
    exp_loss = 1;
    chk("loss_cnt1", 32'(lock_loss_count), 32'(exp_loss));
    tick(17);
    pll_lock_raw = 1'b1;
    tick(18); chk("relock_r18", 32'(ext_rstn), 32'b011);
    tick(1);  chk("relock_r19", 32'(ext_rstn), 32'b111);
    pll_lock_raw = 1'b0;
    tick(3);  chk("loss2_ext", 32'(ext_rstn), 32'b011);
    exp_loss = 2;
    pll_lock_raw = 1'b1;
    tick(5);
    pll_lock_raw = 1'b0;
    tick(1);
    pll_lock_raw = 1'b1;
    tick(18); chk("glitch_g19", 32'(ext_rstn), 32'b011);
    tick(1);  chk("glitch_g20", 32'(ext_rstn), 32'b111);
    chk("glitch_cnt", 32'(lock_loss_count), 32'(exp_loss));

    // 3: pin bounce rejected, long pin low passes
    rstn_pin_raw = 1'b0;
    tick(5);
    rstn_pin_raw = 1'b1;
    tick(10); chk("bounce", 32'(ext_rstn), 32'b111);
    rstn_pin_raw = 1'b0;
    tick(9);  chk("pin_p9", 32'(ext_rstn), 32'b111);
    tick(1);  chk("pin_p10", 32'(ext_rstn), 32'b111);
    tick(1);  chk("pin_p11", 32'(ext_rstn), 32'b101);
    tick(1);
    rstn_pin_raw = 1'b1;
    tick(10); chk("pin_p22", 32'(ext_rstn), 32'b101);
    tick(1);  chk("pin_p23", 32'(ext_rstn), 32'b111);

    // 4: fatal latch, blocked clear, clear, early clear vs min pulse
    fatal_error = 1'b1;
    tick(1);  chk("fat_set", 32'({fatal_latched, ext_rstn}), 32'b1110);
    fatal_error = 1'b0;
    tick(3);  chk("fat_hold", 32'({fatal_latched, ext_rstn}), 32'b1110);
    fatal_error = 1'b1; error_clear = 1'b1;
    tick(1);  chk("fat_setclr", 32'({fatal_latched, ext_rstn}), 32'b1110);
    fatal_error = 1'b0; error_clear = 1'b0;
    tick(2);
    error_clear = 1'b1;
    tick(1);  chk("fat_clr", 32'({fatal_latched, ext_rstn}), 32'b0111);
    error_clear = 1'b0;
    fatal_error = 1'b1;
    tick(1);
    fatal_error = 1'b0; error_clear = 1'b1;
    tick(1);  chk("mp_k1", 32'({fatal_latched, ext_rstn}), 32'b0110);
    error_clear = 1'b0;
    tick(2);  chk("mp_k3", 32'(ext_rstn), 32'b110);
    tick(1);  chk("mp_k4", 32'(ext_rstn), 32'b111);

    // 5: saturate the lock-loss counter, then reset it
    for (int i = 0; i < 300; i++) begin
      pll_lock_raw = 1'b0;
      tick(1);
      pll_lock_raw = 1'b1;
      tick(22);
      if (exp_loss < 255) exp_loss++;
      if (i == 99) chk("loss_cnt102", 32'(lock_loss_count), 32'(exp_loss));
    end
    chk("loss_sat", 32'(lock_loss_count), 32'd255);
    chk("loss_sat_ext", 32'(ext_rstn), 32'b111);
    rstn = 1'b0;
    tick(1);
    chk("rst2_cnt", 32'(lock_loss_count), 32'h0);
    chk("rst2_ext", 32'(ext_rstn), 32'b000);
    rstn = 1'b1;
    tick(19); chk("rst2_up", 32'(ext_rstn), 32'b111);

    // 6: reset during lock qualification and pin debounce
    pll_lock_raw = 1'b0;
    tick(3);  chk("q_loss", 32'(lock_loss_count), 32'd1);
    pll_lock_raw = 1'b1; rstn_pin_raw = 1'b0;
    tick(8);
    rstn = 1'b0;
    tick(1);
    chk("mid_rst_ext", 32'(ext_rstn), 32'b000);
    chk("mid_rst_cnt", 32'(lock_loss_count), 32'h0);
    rstn = 1'b1; rstn_pin_raw = 1'b1;
    tick(10); chk("requal_e10", 32'(ext_rstn), 32'b001);
    tick(8);  chk("requal_e18", 32'(ext_rstn), 32'b011);
    tick(1);  chk("requal_e19", 32'(ext_rstn), 32'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
